// File: rtl/v_rx_text.sv
// ---------------------------------------------------------------------------
// v_rx_text -- inbound text chunk receiver.
//
// Assembles a text chunk from a UART byte stream.  Chunk layout on the wire:
//   type byte (INTERFACE_RX_CHUNK_TYPE), size byte, then `size` payload bytes.
// A completed chunk is published on text_bytes/text_size and held with
// text_ready until the consumer acknowledges it.
//
// Optional feature macro: V_RX_TEXT_TIMEOUT_EN
//   When defined, an inter-byte timeout of TIMEOUT_CYCLES clocks drops a
//   stalled frame (frame_error pulse, back to IDLE).  When undefined, no
//   counter is built and the receiver waits indefinitely mid-frame.
//
// Ports:
//   CLK          in   single clock, rising edge
//   RST          in   asynchronous active-high reset
//   rx_byte      in   received byte, sampled when rx_valid=1
//   rx_valid     in   one-cycle strobe per received byte
//   text_bytes   out  completed payload, byte i at [i*8+7:i*8]
//   text_size    out  payload length of the completed chunk
//   text_ready   out  completed chunk available, held until text_ack
//   text_ack     in   consumer acknowledge (ignored unless a chunk is held)
//   frame_error  out  one-cycle pulse on a dropped frame (oversize/timeout)
//   overrun      out  one-cycle pulse when a byte arrives while text_ready=1
//   dbg_state    out  current FSM state (0 IDLE, 1 SIZE, 2 PAYLOAD, 3 DONE)
//
// Handshake: text_ready rises one cycle after the strobe of the final byte
// and stays high, with text_bytes/text_size stable, until a cycle in which
// text_ack=1; on that edge text_ready drops and the receiver rearms.  Bytes
// strobed while text_ready=1 (including in the ack cycle) are dropped.
// ---------------------------------------------------------------------------
module v_rx_text #(
  parameter int INTERFACE_RX_CHUNK_TYPE = 6,
  parameter int TEXT_BUFFER_BYTE_SIZE   = 33,
  parameter int TEXT_BUFFER_INDEX_SIZE  = 8,
  parameter int TIMEOUT_CYCLES          = 1000000
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic [7:0]                             rx_byte,
  input  logic                                   rx_valid,
  output logic [(TEXT_BUFFER_BYTE_SIZE-1)*8-1:0] text_bytes,
  output logic [TEXT_BUFFER_INDEX_SIZE-1:0]      text_size,
  output logic                                   text_ready,
  input  logic                                   text_ack,
  output logic                                   frame_error,
  output logic                                   overrun,
  output logic [1:0]                             dbg_state
);

  localparam int CAP = TEXT_BUFFER_BYTE_SIZE - 1;
  localparam int BW  = CAP * 8;
  localparam logic [7:0] TYPE_BYTE = 8'(INTERFACE_RX_CHUNK_TYPE);
  localparam logic [7:0] CAP_BYTE  = 8'(CAP);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SIZE    = 2'd1,
    PAYLOAD = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                              state;
  logic [TEXT_BUFFER_INDEX_SIZE-1:0]   size_q;
  logic [TEXT_BUFFER_INDEX_SIZE-1:0]   index;
  logic [BW-1:0]                       work_buf;
  logic [BW-1:0]                       buf_next;

`ifdef V_RX_TEXT_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_cnt;
`endif

  assign dbg_state = state;

  // Working buffer with the current byte dropped into slot [index]; used both
  // to update the buffer and to publish the final byte in the same edge.
  always_comb begin
    buf_next = work_buf;
    for (int i = 0; i < CAP; i++) begin
      if (index == TEXT_BUFFER_INDEX_SIZE'(i)) buf_next[i*8 +: 8] = rx_byte;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      size_q      <= '0;
      index       <= '0;
      work_buf    <= '0;
      text_bytes  <= '0;
      text_size   <= '0;
      text_ready  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
`ifdef V_RX_TEXT_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;

`ifdef V_RX_TEXT_TIMEOUT_EN
      if ((state == SIZE) || (state == PAYLOAD)) begin
        if (rx_valid) tmo_cnt <= '0;
        else          tmo_cnt <= tmo_cnt + 32'd1;
      end else begin
        tmo_cnt <= '0;
      end
`endif

      case (state)
        IDLE: begin
          if (rx_valid && (rx_byte == TYPE_BYTE)) state <= SIZE;
        end

        SIZE: begin
          if (rx_valid) begin
            if (rx_byte > CAP_BYTE) begin
              frame_error <= 1'b1;
              state       <= IDLE;
            end else if (rx_byte == 8'd0) begin
              // Empty chunk: publish immediately.
              text_bytes <= '0;
              text_size  <= '0;
              text_ready <= 1'b1;
              state      <= DONE;
            end else begin
              size_q   <= TEXT_BUFFER_INDEX_SIZE'(rx_byte);
              work_buf <= '0;
              index    <= '0;
              state    <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (rx_valid) begin
            work_buf <= buf_next;
            index    <= index + 1'b1;
            if (index == size_q - 1'b1) begin
              text_bytes <= buf_next;
              text_size  <= size_q;
              text_ready <= 1'b1;
              state      <= DONE;
            end
          end
        end

        DONE: begin
          if (rx_valid) overrun <= 1'b1;
          if (text_ack) begin
            text_ready <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

`ifdef V_RX_TEXT_TIMEOUT_EN
      // Only reachable with no strobe this cycle, so it never competes with
      // the byte handling above.
      if (((state == SIZE) || (state == PAYLOAD)) && !rx_valid &&
          (tmo_cnt == TMO_LAST)) begin
        frame_error <= 1'b1;
        state       <= IDLE;
        tmo_cnt     <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_v_rx_text.sv
module tb_v_rx_text;

  localparam int TYPE_B = 6;
  localparam int BUFSZ  = 33;
  localparam int IDXW   = 8;
  localparam int TMO    = 16;
  localparam int BW     = (BUFSZ - 1) * 8;
  localparam int W      = IDXW + BW;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SIZE    = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [7:0]      rx_byte = '0;
  logic            rx_valid = 1'b0;
  logic [BW-1:0]   text_bytes;
  logic [IDXW-1:0] text_size;
  logic            text_ready;
  logic            text_ack = 1'b0;
  logic            frame_error;
  logic            overrun;
  logic [1:0]      dbg_state;

  v_rx_text #(
    .INTERFACE_RX_CHUNK_TYPE(TYPE_B),
    .TEXT_BUFFER_BYTE_SIZE  (BUFSZ),
    .TEXT_BUFFER_INDEX_SIZE (IDXW),
    .TIMEOUT_CYCLES         (TMO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .text_bytes (text_bytes),
    .text_size  (text_size),
    .text_ready (text_ready),
    .text_ack   (text_ack),
    .frame_error(frame_error),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic send_ack();
    @(negedge CLK);
    text_ack = 1'b1;
    @(negedge CLK);
    text_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push_exp(input logic [IDXW-1:0] sz, input logic [BW-1:0] bytes);
    exp_q.push_back({sz, bytes});
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_ready = 1'b0;
  always @(posedge CLK) begin
    #1;
    if (frame_error) fe_cnt++;
    if (overrun)     ov_cnt++;
    if (text_ready && !prev_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_chunk: got %h expected none", {text_size, text_bytes});
      end else begin
        check("chunk", {text_size, text_bytes}, exp_q.pop_front());
      end
    end
    prev_ready = text_ready;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [BW-1:0] big;

  initial begin
    idle(2);
    // Reset state
    check("rst_ready", W'(text_ready), W'(0));
    check("rst_size",  W'(text_size), W'(0));
    check("rst_bytes", W'(text_bytes), W'(0));
    check("rst_fe",    W'(frame_error), W'(0));
    check("rst_ov",    W'(overrun), W'(0));
    check("rst_state", W'(dbg_state), W'(S_IDLE));
    @(negedge CLK);
    RST = 1'b0;
    idle(1);

    // Ack while idle must be ignored.
    send_ack();
    check("ack_idle_state", W'(dbg_state), W'(S_IDLE));

    // Basic three-byte chunk.
    push_exp(8'd3, BW'(24'h434241));
    send_byte(8'h06); send_byte(8'h03); send_byte(8'h41);
    send_byte(8'h42); send_byte(8'h43);
    check("latency_ready", W'(text_ready), W'(1));
    check("done_state", W'(dbg_state), W'(S_DONE));
    send_ack();
    check("ack_ready", W'(text_ready), W'(0));
    check("ack_state", W'(dbg_state), W'(S_IDLE));

    // Foreign type byte ignored, then empty chunk.
    send_byte(8'h05);
    check("foreign_state", W'(dbg_state), W'(S_IDLE));
    push_exp(8'd0, BW'(0));
    send_byte(8'h06); send_byte(8'h00);
    check("empty_ready", W'(text_ready), W'(1));
    send_ack();

    // Oversize (33) dropped, then a one-byte chunk.
    send_byte(8'h06); send_byte(8'h21);
    check("oversize_fe", W'(fe_cnt), W'(1));
    check("oversize_state", W'(dbg_state), W'(S_IDLE));
    push_exp(8'd1, BW'(8'h5A));
    send_byte(8'h06); send_byte(8'h01); send_byte(8'h5A);
    send_ack();

    // Maximum size (32): byte i carries i+1; ack mid-payload is ignored.
    big = '0;
    for (int i = 0; i < 32; i++) big[i*8 +: 8] = 8'(i + 1);
    push_exp(8'd32, big);
    send_byte(8'h06); send_byte(8'h20);
    for (int i = 0; i < 32; i++) begin
      send_byte(8'(i + 1));
      if (i == 4) begin
        send_ack();
        check("ack_payload_state", W'(dbg_state), W'(S_PAYLOAD));
      end
    end
    check("max_fe", W'(fe_cnt), W'(1));
    send_ack();

    // Overrun while holding a chunk; type value inside payload is data.
    push_exp(8'd2, BW'(16'h0606));
    send_byte(8'h06); send_byte(8'h02); send_byte(8'h06); send_byte(8'h06);
    send_byte(8'h41);
    check("overrun_cnt", W'(ov_cnt), W'(1));
    check("overrun_ready", W'(text_ready), W'(1));
    check("overrun_bytes", W'(text_bytes), W'(BW'(16'h0606)));
    check("overrun_size", W'(text_size), W'(2));
    // Strobe coinciding with ack: dropped with overrun, then IDLE.
    @(negedge CLK);
    rx_byte = 8'h06; rx_valid = 1'b1; text_ack = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0; text_ack = 1'b0;
    check("ack_ov_cnt", W'(ov_cnt), W'(2));
    check("ack_ov_state", W'(dbg_state), W'(S_IDLE));
    check("ack_ov_ready", W'(text_ready), W'(0));

    // Reset mid-frame discards the partial frame.
    send_byte(8'h06); send_byte(8'h04); send_byte(8'h41);
    @(negedge CLK); RST = 1'b1;
    #2;
    check("async_rst_state", W'(dbg_state), W'(S_IDLE));
    @(negedge CLK); RST = 1'b0;
    check("rst_bytes_hold", W'(text_bytes), W'(0));
    push_exp(8'd1, BW'(8'h30));
    send_byte(8'h06); send_byte(8'h01); send_byte(8'h30);
    send_ack();

    // Inter-byte timeout.
    send_byte(8'h06); send_byte(8'h02); send_byte(8'h41);
    idle(TMO);
`ifdef V_RX_TEXT_TIMEOUT_EN
    check("tmo_fe", W'(fe_cnt), W'(2));
    check("tmo_state", W'(dbg_state), W'(S_IDLE));
`else
    check("notmo_fe", W'(fe_cnt), W'(1));
    check("notmo_state", W'(dbg_state), W'(S_PAYLOAD));
    push_exp(8'd2, BW'(16'h4241));
    send_byte(8'h42);
    send_ack();
`endif

    idle(3);
    check("ov_total", W'(ov_cnt), W'(2));
    check("queue_empty", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/v_rx_text.md
V_RX_TEXT -- requirements
Module: v_rx_text

Interface
REQ-001 Parameter INTERFACE_RX_CHUNK_TYPE, default 6, is the chunk type byte that marks an inbound text chunk.
REQ-002 Parameter TEXT_BUFFER_BYTE_SIZE, default 33; payload capacity is TEXT_BUFFER_BYTE_SIZE-1 bytes (32 by default).
REQ-003 Parameter TEXT_BUFFER_INDEX_SIZE, default 8, is the width of the size field and byte index.
REQ-004 Parameter TIMEOUT_CYCLES, default 1000000, is the inter-byte timeout in CLK cycles.
REQ-005 CLK  in  1  single clock; all state updates on its rising edge.
REQ-006 RST  in  1  reset, asynchronous, active-high.
REQ-007 rx_byte  in  8  byte from the UART receiver; sampled only when rx_valid=1.
REQ-008 rx_valid  in  1  one-cycle strobe per received byte.
REQ-009 text_bytes  out  (TEXT_BUFFER_BYTE_SIZE-1)*8  completed payload; byte i is at bits [i*8+7:i*8].
REQ-010 text_size  out  TEXT_BUFFER_INDEX_SIZE  payload length of the completed chunk.
REQ-011 text_ready  out  1  completed chunk available; held high until acknowledged.
REQ-012 text_ack  in  1  consumer acknowledge of text_ready.
REQ-013 frame_error  out  1  one-cycle pulse on a dropped frame (oversize or timeout).
REQ-014 overrun  out  1  one-cycle pulse when a byte arrives while text_ready=1.

Function
REQ-015 The chunk format SHALL be: type byte, then size byte, then exactly size payload bytes.
REQ-016 The FSM states SHALL be IDLE, SIZE, PAYLOAD and DONE.
REQ-017 In IDLE, a strobe with rx_byte==INTERFACE_RX_CHUNK_TYPE moves to SIZE; other type bytes are discarded and the FSM stays in IDLE.
REQ-018 In SIZE, a strobed byte >TEXT_BUFFER_BYTE_SIZE-1 pulses frame_error and returns to IDLE.
REQ-019 In SIZE, a strobed byte of 0 moves directly to DONE with text_size=0 and all-zero text_bytes.
REQ-020 In SIZE, any other strobed byte is latched as the size, clears the working buffer to zero, zeroes the index, and moves to PAYLOAD.
REQ-021 In PAYLOAD, each strobe writes rx_byte to working-buffer slot [index] and increments index; the strobe that fills slot size-1 moves to DONE.
REQ-022 Entering DONE copies the working buffer and size into text_bytes/text_size in the same edge; text_ready is high from the next cycle.
REQ-023 text_bytes and text_size SHALL change only on entry to DONE and stay stable otherwise.
REQ-024 Latency: text_ready rises 1 cycle after the strobe of the final payload byte (or of the size byte when size=0).
REQ-025 In DONE, text_ack=1 deasserts text_ready and returns to IDLE on the next edge.
REQ-026 In DONE, strobes are dropped and pulse overrun; a strobe coinciding with text_ack is also dropped with overrun.
REQ-027 text_ack outside DONE SHALL be ignored.
REQ-028 Payload bytes are not checked against type values; 0x06 inside a payload is data.

Reset
REQ-029 RST=1 SHALL force IDLE asynchronously, including mid-frame, discarding any partial frame.
REQ-030 Reset values: text_bytes=0, text_size=0, text_ready=0, frame_error=0, overrun=0, index=0, timeout counter=0.

Configuration
REQ-031 Macro V_RX_TEXT_TIMEOUT_EN SHALL compile in the inter-byte timeout.
REQ-032 With V_RX_TEXT_TIMEOUT_EN: in SIZE or PAYLOAD, a counter clears on each strobe; reaching TIMEOUT_CYCLES without a strobe pulses frame_error and returns to IDLE.
REQ-033 Without V_RX_TEXT_TIMEOUT_EN: no counter is built, SIZE/PAYLOAD wait indefinitely, and frame_error pulses only on oversize.

Verification
REQ-034 Bytes 06,03,41,42,43 -> text_ready=1, text_size=3, text_bytes[23:0]=0x434241, upper bits 0; ack -> text_ready=0 next cycle.
REQ-035 Bytes 05,06,00 -> the 05 is ignored; text_ready=1, text_size=0, text_bytes=0.
REQ-036 Bytes 06,21 (33) -> frame_error pulses once, state IDLE; then 06,01,5A -> text_size=1, byte0=0x5A.
REQ-037 Chunk completes, no ack, byte 41 strobed -> overrun pulse; text_bytes unchanged; text_ready stays 1.
REQ-038 Bytes 06,04,41 then RST pulse, then 06,01,30 -> text_size=1, byte0=0x30, no residue of 0x41.
REQ-039 With V_RX_TEXT_TIMEOUT_EN, TIMEOUT_CYCLES=16: 06,02,41 then 16 idle cycles -> frame_error pulses, state IDLE; without the macro the FSM stays in PAYLOAD.
